// File: rtl/sna_resp_scheduler.sv
// -----------------------------------------------------------------------------
// sna_resp_scheduler
//   Slave-side NoC adapter response scheduler. Picks one pending AXI4-Lite
//   response (R or B), allocates the lowest-index free virtual channel for it,
//   and emits the response as a two-flit packet (header, tail) toward the
//   router. Each flit waits for the allocated VC's on/off credit.
//
// Build option:
//   SNA_RESP_RR_ARB_EN  defined   -> two-way round-robin between R and B
//                       undefined -> fixed priority, R over B
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   r_header/r_tail/rvalid     pending read response flits
//   rready                     read response accepted (combinational)
//   b_header/b_tail/bvalid     pending write response flits
//   bready                     write response accepted (combinational)
//   is_allocatable[NUM_VC]     per-VC free flag (sampled only in IDLE)
//   is_on_off[NUM_VC]          per-VC may-send flag
//   noc_data                   flit to router (registered, held when idle)
//   is_valid                   one-cycle pulse per flit (registered)
//   vc_sel                     one-hot allocated VC (registered)
//   busy                       packet in flight (HEAD or TAIL)
// -----------------------------------------------------------------------------
module sna_resp_scheduler #(
  parameter int FLIT_W = 37,
  parameter int NUM_VC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] r_header,
  input  logic [FLIT_W-1:0] r_tail,
  input  logic              rvalid,
  output logic              rready,
  input  logic [FLIT_W-1:0] b_header,
  input  logic [FLIT_W-1:0] b_tail,
  input  logic              bvalid,
  output logic              bready,
  input  logic [NUM_VC-1:0] is_allocatable,
  input  logic [NUM_VC-1:0] is_on_off,
  output logic [FLIT_W-1:0] noc_data,
  output logic              is_valid,
  output logic [NUM_VC-1:0] vc_sel,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    TAIL = 2'd2
  } state_t;

  typedef struct packed {
    logic [FLIT_W-1:0] header;
    logic [FLIT_W-1:0] tail;
  } pkt_t;

  state_t            state, state_nxt;
  pkt_t              pkt;
  logic              grant;
  logic              pick_r;
  logic              send;
  logic [NUM_VC-1:0] vc_first;

  assign grant = (state == IDLE) && (rvalid || bvalid) && (|is_allocatable);

`ifdef SNA_RESP_RR_ARB_EN
  // Remembers whether B took the last grant; resets to B so R wins the
  // first tie after reset.
  logic last_grant_b;

  assign pick_r = rvalid && (!bvalid || last_grant_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant_b <= 1'b1;
    else if (grant) last_grant_b <= !pick_r;
  end
`else
  assign pick_r = rvalid;
`endif

  // rst_n gates the readies so no handshake can be seen while in reset.
  assign rready = rst_n && grant && pick_r;
  assign bready = rst_n && grant && !pick_r;

  // Isolate lowest set bit: x & (-x).
  assign vc_first = is_allocatable & (~is_allocatable + NUM_VC'(1));

  // Only the allocated VC's credit matters; other on/off bits are masked.
  assign send = |(is_on_off & vc_sel);

  assign busy = (state == HEAD) || (state == TAIL);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = HEAD;
      HEAD:    if (send)  state_nxt = TAIL;
      TAIL:    if (send)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt      <= '0;
      vc_sel   <= '0;
      noc_data <= '0;
      is_valid <= 1'b0;
    end else begin
      // Default low: a flit is never presented for more than one cycle.
      is_valid <= 1'b0;
      if (grant) begin
        pkt    <= pick_r ? pkt_t'{r_header, r_tail} : pkt_t'{b_header, b_tail};
        vc_sel <= vc_first;
      end
      if (state == HEAD && send) begin
        noc_data <= pkt.header;
        is_valid <= 1'b1;
      end
      if (state == TAIL && send) begin
        noc_data <= pkt.tail;
        is_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sna_resp_scheduler.md
Name: sna_resp_scheduler

Overview:
- Slave-side NoC adapter (SNA) response scheduler. Arbitrates between AXI4-Lite read-response (R) and write-response (B) sources and allocates one free NoC virtual channel (VC) per response.
- Sequences each response as a two-flit packet (header, then tail) onto the NoC, gated per flit by the allocated VC's on/off flow control.
- Sits between the AXI4-Lite slave response channels and the router input port.

Parameters:
- FLIT_W, 37, flit width in bits
- NUM_VC, 8, number of NoC virtual channels

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- r_header  in  FLIT_W  header flit for the pending read response
- r_tail  in  FLIT_W  tail flit for the pending read response
- rvalid  in  1  read response pending
- rready  out  1  read response accepted (combinational)
- b_header  in  FLIT_W  header flit for the pending write response
- b_tail  in  FLIT_W  tail flit for the pending write response
- bvalid  in  1  write response pending
- bready  out  1  write response accepted (combinational)
- is_allocatable  in  NUM_VC  per-VC free flag
- is_on_off  in  NUM_VC  per-VC "may send" flag
- noc_data  out  FLIT_W  flit to router (registered)
- is_valid  out  1  flit valid, one-cycle pulse per flit (registered)
- vc_sel  out  NUM_VC  one-hot allocated VC (registered)
- busy  out  1  high in HEAD or TAIL

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; noc_data=0, is_valid=0, vc_sel=0, busy=0. rready and bready are forced 0 while rst_n=0.
- States: IDLE, HEAD, TAIL (2-bit encoding).
- IDLE, grant condition:
  - A grant occurs when (rvalid | bvalid) & |is_allocatable.
  - The winning source's ready is driven high combinationally in the same cycle. Handshake = valid & ready in one cycle.
- IDLE, grant actions at the clock edge:
  - Capture the winner's header and tail into internal registers.
  - Load vc_sel with the lowest-index set bit of is_allocatable.
  - Move to HEAD.
- IDLE, no grant: both readies stay 0 and the state holds. This includes is_allocatable==0 with a source valid.
- HEAD:
  - If is_on_off & vc_sel is nonzero: noc_data<=captured header, is_valid<=1, move to TAIL.
  - Otherwise: is_valid<=0 and wait.
- TAIL:
  - If is_on_off & vc_sel is nonzero: noc_data<=captured tail, is_valid<=1, move to IDLE.
  - Otherwise: is_valid<=0 and wait.
- is_valid is 0 on every cycle that does not register a flit. No flit is ever held for more than one cycle.
- Latency:
  - Handshake in cycle T0; header visible with is_valid in T2 at the earliest; tail in T3.
  - A new handshake is possible in T3, so the minimum packet period is 3 cycles.
- Output hold:
  - vc_sel changes only on a grant, so it stays valid alongside the tail flit.
  - noc_data holds its last value when is_valid=0.
- Signals ignored outside IDLE:
  - is_allocatable is ignored outside IDLE.
  - The is_on_off bits of unallocated VCs are ignored.
  - rready and bready are 0 outside IDLE regardless of rvalid and bvalid.
- Simultaneous rvalid and bvalid: resolved by the arbitration policy below. Exactly one ready is high; the loser stays pending.
- Reset mid-packet: the in-flight packet is dropped (no tail is emitted) and all outputs return to reset values immediately.

Optional Feature:
- Macro: SNA_RESP_RR_ARB_EN.
- Defined: two-way round-robin arbitration.
  - A last_grant register updates on each grant; its reset value points to B, so R wins the first tie.
  - On a tie, the source not granted last wins.
- Undefined: fixed priority, R over B. No last_grant register is built.

Test Plan:
- Single read: rvalid=1, r_header=0x0_0000_0A01, r_tail=0x1_0000_0A02, is_allocatable=8'b0000_0100, is_on_off=8'hFF. Required: rready=1 for 1 cycle; vc_sel=8'b0000_0100; header pulse in T2 then tail pulse in T3; is_valid pulses exactly twice.
- No VC free: bvalid=1, is_allocatable=0 for 5 cycles, then 8'b1000_0000. Required: bready=0 for those 5 cycles; grant in the 6th cycle; vc_sel=8'b1000_0000.
- Flow control stall: allocate VC0, hold is_on_off[0]=0 for 4 cycles while is_on_off[7:1]=1. Required: no is_valid during the stall; header pulse one cycle after is_on_off[0] rises; tail follows.
- Tie, macro defined: rvalid=bvalid=1 held for 2 packets. Required: R granted first, then B; four flits in order R-hdr, R-tail, B-hdr, B-tail.
- Tie, macro undefined: same stimulus. Required: R granted for both packets while rvalid stays high; bready stays 0.
- Reset in TAIL: assert rst_n=0 after the header pulse. Required: is_valid, noc_data and vc_sel go to 0 immediately; no tail is emitted; after release, a new rvalid is granted normally.
